// File: rtl/frequency_result_sequencer.sv
// Run controller for the frequency analyzer bank: clear -> run -> snapshot -> register
// write-back -> irq. Sole writer of the AXI slave register file.
module frequency_result_sequencer #(
  parameter int unsigned NUMBER_OF_RESULTS = 6,
  parameter int unsigned FIRST_REGISTER    = 1,
  parameter int unsigned CLEAR_CYCLES      = 4,
  parameter int unsigned MAX_RUN_CYCLES    = 100000000
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  input  logic                           start,
  input  logic                           stop,
  input  logic [32*NUMBER_OF_RESULTS-1:0] results,
  output logic                           analyzer_enable,
  output logic                           analyzer_clear_n,
  output logic [1:0]                     register_operation,
  output logic [7:0]                     register_number,
  output logic [31:0]                    register_write,
  output logic                           busy,
  output logic                           irq
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SNAP   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_STATUS = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [7:0]  LP_FIRST_REG  = 8'(FIRST_REGISTER);
  localparam logic [7:0]  LP_STATUS_REG = 8'(FIRST_REGISTER + NUMBER_OF_RESULTS);
  localparam logic [4:0]  LP_LAST_INDEX = 5'(NUMBER_OF_RESULTS - 1);
  localparam logic [31:0] LP_CLEAR_LAST = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] LP_RUN_LAST   = 32'(MAX_RUN_CYCLES - 1);

  logic [2:0]                      r_state;
  logic [2:0]                      w_next_state;
  logic [31:0]                     r_clr_cnt;
  logic [31:0]                     r_run_cnt;
  logic                            r_timeout;
  logic [4:0]                      r_index;
  logic [32*NUMBER_OF_RESULTS-1:0] r_buf;
  logic                            w_timeout_hit;

  always_comb begin
    w_timeout_hit = (MAX_RUN_CYCLES != 0) && (r_run_cnt == LP_RUN_LAST);
    w_next_state  = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_CLEAR;
      S_CLEAR:  if (r_clr_cnt == LP_CLEAR_LAST) w_next_state = S_RUN;
      S_RUN:    if (stop || w_timeout_hit) w_next_state = S_SNAP;
      S_SNAP:   w_next_state = S_WRITE;
      S_WRITE:  w_next_state = S_GAP;
      S_GAP:    w_next_state = (r_index == LP_LAST_INDEX) ? S_STATUS : S_WRITE;
      S_STATUS: w_next_state = S_DONE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state            <= S_IDLE;
      r_clr_cnt          <= '0;
      r_run_cnt          <= '0;
      r_timeout          <= 1'b0;
      r_index            <= '0;
      r_buf              <= '0;
      analyzer_enable    <= 1'b0;
      analyzer_clear_n   <= 1'b1;
      register_operation <= 2'd0;
      register_number    <= '0;
      register_write     <= '0;
      busy               <= 1'b0;
      irq                <= 1'b0;
    end else begin
      r_state            <= w_next_state;
      analyzer_enable    <= (w_next_state == S_RUN);
      analyzer_clear_n   <= (w_next_state != S_CLEAR);
      busy               <= (w_next_state != S_IDLE);
      irq                <= (w_next_state == S_DONE);
      register_operation <= ((w_next_state == S_WRITE) || (w_next_state == S_STATUS)) ? 2'd2 : 2'd0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_clr_cnt <= '0;
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
          end
        end
        S_CLEAR: r_clr_cnt <= r_clr_cnt + 32'd1;
        S_RUN: begin
          if (r_run_cnt != '1) r_run_cnt <= r_run_cnt + 32'd1;
          if (!stop && w_timeout_hit) r_timeout <= 1'b1;
        end
        S_SNAP: begin
          r_buf           <= results;
          r_index         <= '0;
          register_number <= LP_FIRST_REG;
          register_write  <= results[31:0];
        end
        // The snapshot is consumed as a shift register so the next word is always at [31:0].
        S_WRITE: r_buf <= r_buf >> 32;
        S_GAP: begin
          if (r_index != LP_LAST_INDEX) begin
            r_index         <= r_index + 5'd1;
            register_number <= register_number + 8'd1;
            register_write  <= r_buf[31:0];
          end else begin
            register_number <= LP_STATUS_REG;
            register_write  <= {r_timeout, r_run_cnt[30:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_result_sequencer.sv
// Bench for frequency_result_sequencer: two instances (no timeout / 20-cycle timeout) driven
// by shared directed + random stimulus, checked every cycle against a write-back schedule model.
module tb_frequency_result_sequencer;

  localparam int N     = 6;
  localparam int FIRST = 1;
  localparam int CLR   = 4;
  localparam logic [63:0] MAXA = 64'd100000000;
  localparam logic [63:0] MAXB = 64'd20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, stop;
  logic [32*N-1:0] results;

  logic        a_ena, a_clrn, a_busy, a_irq, b_ena, b_clrn, b_busy, b_irq;
  logic [1:0]  a_op, b_op;
  logic [7:0]  a_num, b_num;
  logic [31:0] a_wr, b_wr;

  frequency_result_sequencer #(.NUMBER_OF_RESULTS(N), .FIRST_REGISTER(FIRST),
    .CLEAR_CYCLES(CLR)) dut_a (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .start(start), .stop(stop), .results(results),
    .analyzer_enable(a_ena), .analyzer_clear_n(a_clrn), .register_operation(a_op),
    .register_number(a_num), .register_write(a_wr), .busy(a_busy), .irq(a_irq));

  frequency_result_sequencer #(.NUMBER_OF_RESULTS(N), .FIRST_REGISTER(FIRST),
    .CLEAR_CYCLES(CLR), .MAX_RUN_CYCLES(20)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .start(start), .stop(stop), .results(results),
    .analyzer_enable(b_ena), .analyzer_clear_n(b_clrn), .register_operation(b_op),
    .register_number(b_num), .register_write(b_wr), .busy(b_busy), .irq(b_irq));

  // Model: phase 0 idle, 1 clearing, 2 running, 3 write-back; in write-back, position p runs
  // 0 (snapshot), odd = write slot, even = gap, 2N+1 = status write, 2N+2 = irq.
  int          ph[2];
  int          clrc[2];
  int          p[2];
  logic [63:0] rc[2];
  logic        to[2];
  logic [31:0] snap[2][N];
  logic [7:0]  lnum[2];
  logic [31:0] ldat[2];

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;
  int irq_a = 0;
  logic [39:0] log_a[$];
  logic [39:0] log_b[$];

  initial begin
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; clrc[k] = 0; p[k] = 0; rc[k] = '0; to[k] = 1'b0; lnum[k] = '0; ldat[k] = '0;
    end
  end

  task automatic model_step(input int k);
    logic [63:0] lim;
    logic        tmo;
    int          idx;
    lim = (k == 0) ? MAXA : MAXB;
    if (rst) begin
      ph[k] = 0; p[k] = 0; clrc[k] = 0; rc[k] = '0; to[k] = 1'b0; lnum[k] = '0; ldat[k] = '0;
    end else begin
      case (ph[k])
        0: if (start) begin ph[k] = 1; clrc[k] = 0; rc[k] = '0; to[k] = 1'b0; end
        1: begin clrc[k]++; if (clrc[k] == CLR) ph[k] = 2; end
        2: begin
          tmo = (lim != 0) && (rc[k] == lim - 1);
          if (rc[k] < 64'hFFFF_FFFF) rc[k] = rc[k] + 1;
          if (stop || tmo) begin to[k] = !stop; ph[k] = 3; p[k] = 0; end
        end
        default: begin
          if (p[k] == 0)
            for (int i = 0; i < N; i++) snap[k][i] = results[32*i +: 32];
          if (p[k] == 2*N + 2) ph[k] = 0;
          else begin
            p[k]++;
            if (p[k] == 2*N + 1) begin
              lnum[k] = 8'(FIRST + N);
              ldat[k] = {to[k], rc[k][30:0]};
            end else if (p[k] % 2 == 1) begin
              idx = (p[k] - 1) / 2;
              lnum[k] = 8'(FIRST + idx);
              ldat[k] = snap[k][idx];
            end
          end
        end
      endcase
    end
  endtask

  always @(posedge clk) for (int k = 0; k < 2; k++) model_step(k);

  task automatic chk(input string nm, input int k, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (dut%0d) at %0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic ena, input logic clrn, input logic [1:0] op,
                          input logic [7:0] num, input logic [31:0] wr, input logic bsy,
                          input logic ir);
    logic [1:0] eop;
    eop = (ph[k] == 3 && p[k] % 2 == 1) ? 2'd2 : 2'd0;
    chk("analyzer_enable", k, 40'(ena), 40'(ph[k] == 2));
    chk("analyzer_clear_n", k, 40'(clrn), 40'(ph[k] != 1));
    chk("busy", k, 40'(bsy), 40'(ph[k] != 0));
    chk("irq", k, 40'(ir), 40'(ph[k] == 3 && p[k] == 2*N + 2));
    chk("register_operation", k, 40'(op), 40'(eop));
    chk("register_number", k, 40'(num), 40'(lnum[k]));
    chk("register_write", k, 40'(wr), 40'(ldat[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, a_ena, a_clrn, a_op, a_num, a_wr, a_busy, a_irq);
      cmp_inst(1, b_ena, b_clrn, b_op, b_num, b_wr, b_busy, b_irq);
    end
    if (a_op == 2'd2) log_a.push_back({a_num, a_wr});
    if (b_op == 2'd2) log_b.push_back({b_num, b_wr});
    if (a_irq === 1'b1) irq_a++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_run_a(input string nm);
    int n = 0;
    while (ph[0] != 2 && n < 50) begin cyc(1); n++; end
    if (ph[0] != 2) begin
      n_cmp++; n_mis++;
      $display("FAIL %s: RUN not reached within 50 cycles", nm);
    end
  endtask

  task automatic wait_irq_a(input string nm);
    int n = 0;
    while (a_irq !== 1'b1 && n < 100) begin cyc(1); n++; end
    if (a_irq !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL %s: irq not seen within 100 cycles", nm);
    end
  endtask

  task automatic wait_wb_pos_a(input int pos, input string nm);
    int n = 0;
    while (!(ph[0] == 3 && p[0] == pos) && n < 100) begin cyc(1); n++; end
    if (!(ph[0] == 3 && p[0] == pos)) begin
      n_cmp++; n_mis++;
      $display("FAIL %s: write-back slot %0d not reached", nm, pos);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic rand_results();
    for (int i = 0; i < N; i++) results[32*i +: 32] = $urandom();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; results = '0;
    cyc(2);
    chk_en = 1'b1;
    chk("reset_enable", 0, 40'(a_ena), 40'd0);
    chk("reset_clear_n", 0, 40'(a_clrn), 40'd1);
    chk("reset_reg_op", 0, 40'(a_op), 40'd0);
    chk("reset_busy", 0, 40'(a_busy), 40'd0);
    cyc(1);
    rst = 1'b0;
    cyc(2);

    // Stop 50 cycles into RUN; dut_b times out after 20.
    for (int i = 0; i < N; i++) results[32*i +: 32] = 32'h100 + 32'(i);
    log_a.delete(); log_b.delete(); irq_a = 0;
    pulse_start();
    wait_run_a("t1");
    cyc(49);
    pulse_stop();
    wait_irq_a("t1");
    cyc(2);
    chk("t1_write_count", 0, 40'(log_a.size()), 40'd7);
    if (log_a.size() >= 7) begin
      for (int i = 0; i < N; i++)
        chk("t1_result_write", 0, log_a[i], {8'(FIRST + i), 32'h100 + 32'(i)});
      chk("t1_status_write", 0, log_a[6], {8'd7, 32'd50});
    end
    chk("t1_irq_pulses", 0, 40'(irq_a), 40'd1);
    chk("t2_write_count", 1, 40'(log_b.size()), 40'd7);
    if (log_b.size() >= 7) begin
      chk("t2_first_write", 1, log_b[0], {8'd1, 32'h100});
      chk("t2_status_write", 1, log_b[6], {8'd7, 32'h8000_0014});
    end

    // start+stop together in IDLE, then results churn during write-back.
    log_a.delete();
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    for (int j = 0; j < CLR; j++) begin
      chk("t6_clear_low", 0, 40'(a_clrn), 40'd0);
      chk("t6_enable_low", 0, 40'(a_ena), 40'd0);
      cyc(1);
    end
    chk("t6_clear_released", 0, 40'(a_clrn), 40'd1);
    chk("t6_enable_high", 0, 40'(a_ena), 40'd1);
    cyc(29);
    chk("t6_enable_held", 0, 40'(a_ena), 40'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    for (int i = 0; i < N; i++) results[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    for (int j = 0; j < 2*N + 3; j++) begin cyc(1); rand_results(); end
    cyc(2);
    chk("t3_write_count", 0, 40'(log_a.size()), 40'd7);
    if (log_a.size() >= 7) begin
      for (int i = 0; i < N; i++)
        chk("t3_snapshot_write", 0, log_a[i], {8'(FIRST + i), 32'hA5A5_0000 + 32'(i)});
      chk("t3_status_write", 0, log_a[6], {8'd7, 32'd30});
    end

    // start/stop pulses during write-back are dropped.
    pulse_start();
    wait_run_a("t4");
    cyc(9);
    pulse_stop();
    wait_wb_pos_a(3, "t4");
    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    wait_wb_pos_a(7, "t4");
    pulse_start();
    wait_irq_a("t4");
    cyc(1);
    chk("t4_idle_busy", 0, 40'(a_busy), 40'd0);
    cyc(3);
    chk("t4_still_idle", 0, 40'(a_busy), 40'd0);
    chk("t4_no_clear", 0, 40'(a_clrn), 40'd1);

    // Reset on the third write, then a clean run.
    rand_results();
    pulse_start();
    wait_run_a("t5a");
    cyc(9);
    pulse_stop();
    wait_wb_pos_a(5, "t5");
    chk("t5_third_write_reg", 0, 40'(a_num), 40'd3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t5_reset_op", 0, 40'(a_op), 40'd0);
    chk("t5_reset_num", 0, 40'(a_num), 40'd0);
    chk("t5_reset_wr", 0, 40'(a_wr), 40'd0);
    chk("t5_reset_busy", 0, 40'(a_busy), 40'd0);
    chk("t5_reset_irq", 0, 40'(a_irq), 40'd0);
    log_a.delete();
    pulse_start();
    chk("t5_restart_clear", 0, 40'(a_clrn), 40'd0);
    wait_run_a("t5b");
    cyc(4);
    pulse_stop();
    wait_irq_a("t5b");
    cyc(2);
    chk("t5_write_count", 0, 40'(log_a.size()), 40'd7);
    if (log_a.size() >= 7) chk("t5_status_write", 0, log_a[6], {8'd7, 32'd5});

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rand_results();
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
